// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared types and defaults for the VGA pixel path.
//   - H_ACT_DEF / V_ACT_DEF : default active area (640x480)
//   - rgb_t                 : 24-bit packed pixel {r, g, b}
//   - feeder_state_t        : prefetch FSM states of vga_pixel_feeder
package vga_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } feeder_state_t;

    // Number of pixels in one frame's active area.
    function automatic int frame_pixels(input int h_act, input int v_act);
        return h_act * v_act;
    endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo
//   Synchronous single-clock FIFO of DEPTH rgb_t words with show-ahead head.
//   Ports:
//     clk_i, rst_i     : clock, synchronous active-high reset
//     flush_i          : empties the FIFO this cycle (push/pop ignored)
//     push_i           : write push_data_i (ignored when full and not popping)
//     push_data_i      : word to write
//     pop_i            : consume head_o (ignored when empty)
//     head_o           : oldest stored word, valid when !empty_o
//     count_o          : number of stored words, 0..DEPTH
//     empty_o, full_o  : occupancy flags
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  rgb_t                   push_data_i,
    input  logic                   pop_i,
    output rgb_t                   head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);

    rgb_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_write;
    logic          do_read;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees a slot
    // in the same cycle.
    assign do_read  = pop_i && !empty_o;
    assign do_write = push_i && (!full_o || do_read);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a word is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && do_write) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder
//   Prefetches frame pixels from memory into a small FIFO and hands one
//   pixel per cycle to the VGA controller.
//   Ports:
//     iCLK, iRST            : pixel clock, synchronous active-high reset
//     iFrame_Start          : one-cycle pulse; restart at address 0, flush
//     iRead_Request         : controller consumes one pixel this cycle
//     oMem_Req, oMem_Addr   : read request and linear pixel address
//     iMem_Ack              : request accepted (oMem_Req && iMem_Ack)
//     iMem_Valid, iMem_Data : in-order read returns {R, G, B}
//     oRed, oGreen, oBlue   : registered pixel, 1 cycle after the pop
//     oUnderflow            : sticky, set by a pop from an empty FIFO
//     oState                : current FSM state (feeder_state_t encoding)
//
//   Memory handshake: a request transfers in any cycle where oMem_Req and
//   iMem_Ack are both high; oMem_Req/oMem_Addr depend only on registered
//   state. Each transfer yields exactly one iMem_Valid later, in order.
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 19,
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFrame_Start,
    input  logic              iRead_Request,
    output logic              oMem_Req,
    output logic [ADDR_W-1:0] oMem_Addr,
    input  logic              iMem_Ack,
    input  logic              iMem_Valid,
    input  logic [23:0]       iMem_Data,
    output logic [7:0]        oRed,
    output logic [7:0]        oGreen,
    output logic [7:0]        oBlue,
    output logic              oUnderflow,
    output logic [1:0]        oState
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'(frame_pixels(H_ACT, V_ACT) - 1);

    feeder_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     disc_q, disc_d;
    rgb_t              rgb_q, rgb_d;
    logic              uf_q, uf_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    rgb_t              fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic [SW-1:0]     credit_sum;
    logic              mem_req;
    logic              accept;
    logic              ret_drop;
    logic              ret_live;
    logic              ret_dec;
    logic [CW:0]       inflight;

    vga_pixel_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .flush_i    (fifo_flush),
        .push_i     (fifo_push),
        .push_data_i(iMem_Data),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Credit: stored words, live requests and to-be-dropped returns all
    // reserve a FIFO slot, so a return can never find the FIFO full.
    always_comb begin
        credit_sum = SW'(fifo_count) + SW'(outst_q) + SW'(disc_q);
        mem_req    = (state_q == FETCH) && (credit_sum < SW'(DEPTH));
        accept     = mem_req && iMem_Ack;
        // Returns belonging to a flushed frame arrive first (in order).
        ret_drop   = iMem_Valid && (disc_q != '0);
        ret_live   = iMem_Valid && (disc_q == '0);
        // Saturating: a stray return after reset never wraps the counter.
        ret_dec    = ret_live && (outst_q != '0);
        inflight   = {1'b0, disc_q} + {1'b0, outst_q} + {{CW{1'b0}}, accept};
    end

    // Returns are ignored in IDLE so late data from before a reset is lost.
    assign fifo_flush = iFrame_Start;
    assign fifo_push  = ret_live && (state_q != IDLE) && !iFrame_Start &&
                        (!fifo_full || fifo_pop);
    assign fifo_pop   = iRead_Request && !iFrame_Start && !fifo_empty;

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (iFrame_Start) begin
            state_d = FETCH;
        end else if ((state_q == FETCH) && accept && (addr_q == LAST_ADDR)) begin
            state_d = DONE;
        end
    end

    // Address, outstanding and discard counters.
    always_comb begin
        addr_d  = addr_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        if (iFrame_Start) begin
            addr_d  = '0;
            outst_d = '0;
            // Everything still in flight (including this cycle's accept)
            // belongs to the old frame; a return this cycle is one of them.
            if (iMem_Valid && (inflight != '0)) begin
                disc_d = CW'(inflight - 1'b1);
            end else begin
                disc_d = CW'(inflight);
            end
        end else begin
            if (accept) begin
                addr_d = addr_q + 1'b1;
            end
            if (ret_drop) begin
                disc_d = disc_q - 1'b1;
            end
            case ({accept, ret_dec})
                2'b10:   outst_d = outst_q + 1'b1;
                2'b01:   outst_d = outst_q - 1'b1;
                default: outst_d = outst_q;
            endcase
        end
    end

    // Output pixel and underflow flag. A frame start overrides a pop.
    always_comb begin
        rgb_d = rgb_q;
        uf_d  = uf_q;
        if (iFrame_Start) begin
            rgb_d = '0;
            uf_d  = 1'b0;
        end else if (iRead_Request) begin
            if (fifo_empty) begin
                rgb_d = '0;
                uf_d  = 1'b1;
            end else begin
                rgb_d = fifo_head;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            outst_q <= '0;
            disc_q  <= '0;
            rgb_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            rgb_q   <= rgb_d;
            uf_q    <= uf_d;
        end
    end

    assign oMem_Req   = mem_req;
    assign oMem_Addr  = addr_q;
    assign oRed       = rgb_q.r;
    assign oGreen     = rgb_q.g;
    assign oBlue      = rgb_q.b;
    assign oUnderflow = uf_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb_vga_pixel_feeder
//   Drives vga_pixel_feeder with a small frame (8x4 = 32 pixels, DEPTH 16)
//   and an in-order memory responder with configurable ack pattern and
//   return latency. Returned data is {tag[3:0], addr[19:0]}; the tag
//   changes on every frame start so data of a flushed frame is recognisable.
module tb_vga_pixel_feeder;
    import vga_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 19;
    localparam int H_ACT  = 8;
    localparam int V_ACT  = 4;
    localparam int TOTAL  = H_ACT * V_ACT;

    // ---------------- clock / reset / DUT ----------------
    logic              iCLK;
    logic              iRST;
    logic              iFrame_Start;
    logic              iRead_Request;
    logic              oMem_Req;
    logic [ADDR_W-1:0] oMem_Addr;
    logic              iMem_Ack;
    logic              iMem_Valid;
    logic [23:0]       iMem_Data;
    logic [7:0]        oRed;
    logic [7:0]        oGreen;
    logic [7:0]        oBlue;
    logic              oUnderflow;
    logic [1:0]        oState;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    vga_pixel_feeder #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iFrame_Start (iFrame_Start),
        .iRead_Request(iRead_Request),
        .oMem_Req     (oMem_Req),
        .oMem_Addr    (oMem_Addr),
        .iMem_Ack     (iMem_Ack),
        .iMem_Valid   (iMem_Valid),
        .iMem_Data    (iMem_Data),
        .oRed         (oRed),
        .oGreen       (oGreen),
        .oBlue        (oBlue),
        .oUnderflow   (oUnderflow),
        .oState       (oState)
    );

    // ---------------- reference model state ----------------
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [23:0] exp_q[$];      // pixels the FIFO should hold, oldest first
    logic [23:0] pend_data[$];  // accepted requests awaiting their return
    int          pend_due[$];
    int          stale_cnt;     // oldest pend entries that belong to a dead frame
    int          last_due;
    logic [23:0] exp_rgb;
    logic        exp_uf;
    int          m_state;       // 0 idle, 1 fetching, 2 frame fully requested
    int          m_addr;
    logic [3:0]  tag;
    int          lat_min;
    int          lat_max;
    int          ack_mode;      // 0 never, 1 always, 2 random

    // ---------------- driver + memory responder ----------------
    // One clock cycle: drive inputs at the falling edge, advance the model
    // at the rising edge, return 1 time unit later.
    task automatic cycle(input logic fs, input logic rd, input logic rst);
        logic        req;
        logic [ADDR_W-1:0] addr;
        logic        exp_req;
        logic        ack;
        logic        vld;
        logic        v_stale;
        logic [23:0] vdata;
        logic        was_idle;
        int          c;
        int          due;
        c = cyc;
        @(negedge iCLK);
        req     = oMem_Req;
        addr    = oMem_Addr;
        exp_req = (m_state == 1) && ((exp_q.size() + pend_data.size()) < DEPTH);
        checks++;
        if (req !== exp_req) begin
            failures++;
            $display("FAIL mem_req cyc=%0d got=%b exp=%b", c, req, exp_req);
        end
        if (req === 1'b1 && exp_req) begin
            checks++;
            if (addr !== ADDR_W'(m_addr)) begin
                failures++;
                $display("FAIL mem_addr cyc=%0d got=%0d exp=%0d", c, addr, m_addr);
            end
        end
        case (ack_mode)
            0:       ack = 1'b0;
            1:       ack = 1'b1;
            default: ack = 1'($urandom_range(0, 1));
        endcase
        vld   = 1'b0;
        vdata = 24'($urandom);
        if (pend_due.size() > 0 && pend_due[0] <= c) begin
            vld   = 1'b1;
            vdata = pend_data[0];
        end
        iRST          = rst;
        iFrame_Start  = fs;
        iRead_Request = rd;
        iMem_Ack      = ack;
        iMem_Valid    = vld;
        iMem_Data     = vdata;
        @(posedge iCLK);
        cyc++;

        v_stale = 1'b0;
        if (vld) begin
            void'(pend_data.pop_front());
            void'(pend_due.pop_front());
            if (stale_cnt > 0) begin
                stale_cnt--;
                v_stale = 1'b1;
            end
        end
        if (req === 1'b1 && ack) begin
            due = c + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_data.push_back({tag, 20'(addr)});
            pend_due.push_back(due);
        end
        was_idle = (m_state == 0);
        if (rst || fs) begin
            exp_q.delete();
            exp_rgb   = '0;
            exp_uf    = 1'b0;
            m_addr    = 0;
            stale_cnt = pend_data.size();
            m_state   = rst ? 0 : 1;
            if (!rst) tag = tag + 4'd1;
        end else begin
            if (req === 1'b1 && ack && m_state == 1) begin
                m_addr++;
                if (m_addr == TOTAL) m_state = 2;
            end
            if (rd) begin
                if (exp_q.size() == 0) begin
                    exp_rgb = '0;
                    exp_uf  = 1'b1;
                end else begin
                    exp_rgb = exp_q.pop_front();
                end
            end
            if (vld && !v_stale && !was_idle) exp_q.push_back(vdata);
        end
        checks++;
        if ((exp_q.size() + pend_data.size()) > DEPTH) begin
            failures++;
            $display("FAIL credit cyc=%0d got=%0d max=%0d", c,
                     exp_q.size() + pend_data.size(), DEPTH);
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iRST = 1'b1; iFrame_Start = 1'b0; iRead_Request = 1'b0;
        iMem_Ack = 1'b0; iMem_Valid = 1'b0; iMem_Data = '0;
        repeat (2) @(posedge iCLK);
        #1;
        checks++;
        if (oMem_Req !== 1'b0 || oMem_Addr !== '0 || {oRed, oGreen, oBlue} !== 24'h0 ||
            oUnderflow !== 1'b0 || oState !== 2'(IDLE)) begin
            failures++;
            $display("FAIL reset_vals got req=%b addr=%0d rgb=%h uf=%b st=%0d exp 0/0/0/0/0",
                     oMem_Req, oMem_Addr, {oRed, oGreen, oBlue}, oUnderflow, oState);
        end
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (oMem_Req !== 1'b0 || oState !== 2'(IDLE)) begin
                failures++;
                $display("FAIL idle_noreq got req=%b st=%0d exp 0/0", oMem_Req, oState);
            end
        end
    endtask

    task automatic test_fill();
        lat_min = 1; lat_max = 1; ack_mode = 1;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (oMem_Req !== 1'b0 || oMem_Addr !== ADDR_W'(16) || oState !== 2'(FETCH)) begin
            failures++;
            $display("FAIL fill_stop got req=%b addr=%0d st=%0d exp 0/16/1",
                     oMem_Req, oMem_Addr, oState);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== 24'(i) || oUnderflow !== 1'b0) begin
                failures++;
                $display("FAIL fill_pop%0d got=%h/%b exp=%h/0", i, {oRed, oGreen, oBlue},
                         oUnderflow, 24'(i));
            end
        end
    endtask

    task automatic test_full_frame();
        logic [23:0] last_pix;
        logic        rd;
        int          i;
        last_pix = 'x;
        for (i = 0; i < 300; i++) begin
            if (m_state == 2 && pend_data.size() == 0 && exp_q.size() == 0) break;
            rd = (exp_q.size() > 0);
            cycle(1'b0, rd, 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== exp_uf) begin
                failures++;
                $display("FAIL frame_rgb cyc=%0d got=%h/%b exp=%h/%b", cyc,
                         {oRed, oGreen, oBlue}, oUnderflow, exp_rgb, exp_uf);
            end
            if (rd) last_pix = {oRed, oGreen, oBlue};
        end
        checks++;
        if (i >= 300) begin
            failures++;
            $display("FAIL frame_timeout got=%0d cycles exp<300", i);
        end
        checks++;
        if (last_pix !== 24'h00001F || oState !== 2'(DONE) || oMem_Req !== 1'b0) begin
            failures++;
            $display("FAIL frame_end got last=%h st=%0d req=%b exp 00001f/2/0",
                     last_pix, oState, oMem_Req);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (oMem_Req !== 1'b0 || oState !== 2'(DONE)) begin
                failures++;
                $display("FAIL done_quiet got req=%b st=%0d exp 0/2", oMem_Req, oState);
            end
        end
    endtask

    task automatic test_underflow();
        lat_min = 4; lat_max = 4; ack_mode = 1;
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if ({oRed, oGreen, oBlue} !== 24'h0 || oUnderflow !== 1'b0) begin
            failures++;
            $display("FAIL uf_flushwins got=%h/%b exp=000000/0", {oRed, oGreen, oBlue}, oUnderflow);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({oRed, oGreen, oBlue} !== 24'h0 || oUnderflow !== 1'b1) begin
            failures++;
            $display("FAIL uf_first got=%h/%b exp=000000/1", {oRed, oGreen, oBlue}, oUnderflow);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, (i < 8), 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== 1'b1) begin
                failures++;
                $display("FAIL uf_sticky cyc=%0d got=%h/%b exp=%h/1", cyc,
                         {oRed, oGreen, oBlue}, oUnderflow, exp_rgb);
            end
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (oUnderflow !== 1'b0 || {oRed, oGreen, oBlue} !== 24'h0) begin
            failures++;
            $display("FAIL uf_clear got=%h/%b exp=000000/0", {oRed, oGreen, oBlue}, oUnderflow);
        end
    endtask

    task automatic test_flush_discard();
        logic rd;
        logic got;
        ack_mode = 0;
        for (int i = 0; i < 60 && pend_data.size() > 0; i++) cycle(1'b0, 1'b0, 1'b0);
        lat_min = 6; lat_max = 6; ack_mode = 1;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        ack_mode = 0;
        cycle(1'b1, 1'b0, 1'b0);
        ack_mode = 1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            rd = (exp_q.size() > 0);
            cycle(1'b0, rd, 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== 1'b0) begin
                failures++;
                $display("FAIL discard_rgb cyc=%0d got=%h/%b exp=%h/0", cyc,
                         {oRed, oGreen, oBlue}, oUnderflow, exp_rgb);
            end
            if (rd) begin
                got = 1'b1;
                checks++;
                if ({oRed, oGreen, oBlue} !== {tag, 20'd0}) begin
                    failures++;
                    $display("FAIL discard_first got=%h exp=%h", {oRed, oGreen, oBlue}, {tag, 20'd0});
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL discard_timeout got=no pixel exp=pixel");
        end
    endtask

    task automatic test_random();
        logic rd;
        int   n;
        lat_min = 1; lat_max = 6; ack_mode = 2;
        cycle(1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 2000 && n < TOTAL; i++) begin
            rd = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            cycle(1'b0, rd, 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== 1'b0) begin
                failures++;
                $display("FAIL rand_rgb cyc=%0d got=%h/%b exp=%h/0", cyc,
                         {oRed, oGreen, oBlue}, oUnderflow, exp_rgb);
            end
            if (rd) begin
                checks++;
                if ({oRed, oGreen, oBlue} !== {tag, 20'(n)}) begin
                    failures++;
                    $display("FAIL rand_seq got=%h exp=%h", {oRed, oGreen, oBlue}, {tag, 20'(n)});
                end
                n++;
            end
        end
        checks++;
        if (n != TOTAL || oState !== 2'(DONE)) begin
            failures++;
            $display("FAIL rand_end got n=%0d st=%0d exp %0d/2", n, oState, TOTAL);
        end
    endtask

    task automatic test_back_to_back();
        logic real_pop;
        int   n;
        lat_min = 1; lat_max = 1; ack_mode = 1;
        cycle(1'b1, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            real_pop = (exp_q.size() > 0);
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== exp_uf) begin
                failures++;
                $display("FAIL b2b_rgb cyc=%0d got=%h/%b exp=%h/%b", cyc,
                         {oRed, oGreen, oBlue}, oUnderflow, exp_rgb, exp_uf);
            end
            if (real_pop) begin
                checks++;
                if ({oRed, oGreen, oBlue} !== {tag, 20'(n)}) begin
                    failures++;
                    $display("FAIL b2b_seq got=%h exp=%h", {oRed, oGreen, oBlue}, {tag, 20'(n)});
                end
                n++;
            end
        end
        checks++;
        if (n != TOTAL || oUnderflow !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end got n=%0d uf=%b exp %0d/1", n, oUnderflow, TOTAL);
        end
    endtask

    task automatic test_reset_mid();
        lat_min = 5; lat_max = 5; ack_mode = 1;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, (i > 3), 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (oMem_Req !== 1'b0 || oMem_Addr !== '0 || {oRed, oGreen, oBlue} !== 24'h0 ||
            oUnderflow !== 1'b0 || oState !== 2'(IDLE)) begin
            failures++;
            $display("FAIL rstmid_vals got req=%b addr=%0d rgb=%h uf=%b st=%0d exp 0/0/0/0/0",
                     oMem_Req, oMem_Addr, {oRed, oGreen, oBlue}, oUnderflow, oState);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({oRed, oGreen, oBlue} !== 24'h0 || oUnderflow !== 1'b1 || oState !== 2'(IDLE)) begin
            failures++;
            $display("FAIL rstmid_late got=%h/%b st=%0d exp=000000/1/0",
                     {oRed, oGreen, oBlue}, oUnderflow, oState);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        stale_cnt = 0; last_due = 0; exp_rgb = '0; exp_uf = 1'b0;
        m_state = 0; m_addr = 0; tag = 4'hF;
        lat_min = 1; lat_max = 1; ack_mode = 1;
        test_reset();
        test_fill();
        test_full_frame();
        test_underflow();
        test_flush_discard();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
